// File: rtl/dfs_pkg.sv
// Shared types and defaults for the DFS multi-channel frequency controller.
package dfs_pkg;

   typedef enum logic [1:0] {
      S_BOOT     = 2'd0,
      S_SCAN     = 2'd1,
      S_WAIT_ACK = 2'd2
   } state_t;

   localparam int DEF_N_FREQ = 6;
   localparam int DEF_FREQS [DEF_N_FREQ] = '{480, 440, 400, 360, 320, 280};

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last accepted grant.
module rr_arbiter
   import dfs_pkg::*;
#(
   parameter int N = 4
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = ch_w(N);

   logic [PW-1:0] r_last;
   logic [PW-1:0] w_gnt_idx;
   logic          w_found;

   always_comb begin
      grant     = '0;
      w_found   = 1'b0;
      w_gnt_idx = r_last;
      for (int off = 1; off <= N; off++) begin
         if (!w_found && req[(int'(r_last) + off) % N]) begin
            w_found   = 1'b1;
            w_gnt_idx = PW'((int'(r_last) + off) % N);
            grant[(int'(r_last) + off) % N] = 1'b1;
         end
      end
   end

   // Reset to the top channel so channel 0 wins the first search.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= PW'(N - 1);
      end else if (advance && w_found) begin
         r_last <= w_gnt_idx;
      end
   end

endmodule

// File: rtl/multi_freq_ctrl.sv
// Multi-channel DFS frequency controller: boot-time programming, round-robin
// FIFO servicing, ack timeout with bounded re-issue and sticky error/clamp flags.
//
// state      | meaning
// S_BOOT     | walk channels in order, programming the boot frequency
// S_SCAN     | grant one FIFO request per cycle, pop and maybe issue
// S_WAIT_ACK | command outstanding; wait for ack, re-issue on timeout
module multi_freq_ctrl
   import dfs_pkg::*;
#(
   parameter int DATA_WIDTH  = 13,
   parameter int N_FREQ      = DEF_N_FREQ,
   parameter int FREQS [N_FREQ] = DEF_FREQS,
   parameter int PLL_FREQ    = 1,
   parameter int N_CH        = 4,
   parameter int IDX_W       = 8,
   parameter int ACK_TIMEOUT = 64,
   parameter int MAX_RETRY   = 3,
   localparam int CH_W       = ch_w(N_CH)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         enable_i,
   input  logic [N_CH*IDX_W-1:0]   freq_data_i,
   input  logic [N_CH-1:0]         freq_empty_i,
   output logic [N_CH-1:0]         freq_pop_o,
   output logic                    dfs_en_o,
   output logic [CH_W-1:0]         dfs_ch_o,
   output logic [DATA_WIDTH-1:0]   dfs_data_o,
   input  logic                    dfs_ack_i,
   output logic [N_CH*IDX_W-1:0]   cur_idx_o,
   output logic [N_CH-1:0]         err_o,
   output logic [N_CH-1:0]         clamp_o
);

   localparam int TMR_W = ch_w(ACK_TIMEOUT);
   localparam int RET_W = ch_w(MAX_RETRY + 1);
   localparam int BC_W  = CH_W + 1;
   localparam logic [DATA_WIDTH-1:0] BOOT_WORD = DATA_WIDTH'(FREQS[PLL_FREQ]);

   state_t                       r_state;
   state_t                       w_next_state;
   logic [BC_W-1:0]              r_boot_ch;
   logic                         r_dfs_en;
   logic [CH_W-1:0]              r_dfs_ch;
   logic [DATA_WIDTH-1:0]        r_dfs_data;
   logic [IDX_W-1:0]             r_txn_idx;
   logic [TMR_W-1:0]             r_timer;
   logic [RET_W-1:0]             r_retry;
   logic [N_CH-1:0][IDX_W-1:0]   r_cur_idx;
   logic [N_CH-1:0]              r_err;
   logic [N_CH-1:0]              r_clamp;

   logic [N_CH-1:0][IDX_W-1:0]   w_fdata;
   logic [N_CH-1:0]              w_req;
   logic [N_CH-1:0]              w_grant;
   logic [CH_W-1:0]              w_gnt_ch;
   logic [IDX_W-1:0]             w_gnt_raw;
   logic                         w_gnt_clamped;
   logic [IDX_W-1:0]             w_gnt_idx;
   logic [CH_W-1:0]              w_boot_sel;
   logic                         w_issue;
   logic [CH_W-1:0]              w_issue_ch;
   logic [IDX_W-1:0]             w_issue_idx;
   logic [DATA_WIDTH-1:0]        w_issue_word;
   logic [N_CH-1:0]              w_pop;
   logic                         w_advance;
   logic [N_CH-1:0]              w_clamp_set;
   logic                         w_done;
   logic                         w_commit;
   logic                         w_err_set;
   logic                         w_boot_inc;
   logic                         w_retry;

   assign w_fdata    = freq_data_i;
   assign w_req      = enable_i & ~freq_empty_i & {N_CH{r_state == S_SCAN}};
   assign w_boot_sel = r_boot_ch[CH_W-1:0];

   rr_arbiter #(.N(N_CH)) u_rr_arbiter (
      .clk     (clk),
      .rst     (rst),
      .req     (w_req),
      .advance (w_advance),
      .grant   (w_grant)
   );

   always_comb begin
      w_gnt_ch = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (w_grant[k]) w_gnt_ch = CH_W'(k);
      end
      w_gnt_raw     = w_fdata[w_gnt_ch];
      w_gnt_clamped = (w_gnt_raw >= IDX_W'(N_FREQ));
      w_gnt_idx     = w_gnt_clamped ? IDX_W'(N_FREQ - 1) : w_gnt_raw;
   end

   always_comb begin
      w_issue_word = '0;
      for (int k = 0; k < N_FREQ; k++) begin
         if (w_issue_idx == IDX_W'(k)) w_issue_word = DATA_WIDTH'(FREQS[k]);
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_issue      = 1'b0;
      w_issue_ch   = r_dfs_ch;
      w_issue_idx  = r_txn_idx;
      w_pop        = '0;
      w_advance    = 1'b0;
      w_clamp_set  = '0;
      w_done       = 1'b0;
      w_commit     = 1'b0;
      w_err_set    = 1'b0;
      w_boot_inc   = 1'b0;
      w_retry      = 1'b0;
      case (r_state)
         S_BOOT: begin
            if (r_boot_ch >= BC_W'(N_CH)) begin
               w_next_state = S_SCAN;
            end else if (enable_i[w_boot_sel]) begin
               w_issue      = 1'b1;
               w_issue_ch   = w_boot_sel;
               w_issue_idx  = IDX_W'(PLL_FREQ);
               w_next_state = S_WAIT_ACK;
            end else begin
               w_boot_inc = 1'b1;
            end
         end
         S_SCAN: begin
            if (|w_grant) begin
               w_pop       = w_grant;
               w_advance   = 1'b1;
               w_clamp_set = w_grant & {N_CH{w_gnt_clamped}};
               // A request matching the committed index is consumed silently.
               if (w_gnt_idx != r_cur_idx[w_gnt_ch]) begin
                  w_issue      = 1'b1;
                  w_issue_ch   = w_gnt_ch;
                  w_issue_idx  = w_gnt_idx;
                  w_next_state = S_WAIT_ACK;
               end
            end
         end
         S_WAIT_ACK: begin
            if (dfs_ack_i) begin
               w_commit = 1'b1;
               w_done   = 1'b1;
            end else if (r_timer == '0) begin
               if (r_retry == RET_W'(MAX_RETRY)) begin
                  w_err_set = 1'b1;
                  w_done    = 1'b1;
               end else begin
                  w_retry = 1'b1;
               end
            end
            if (w_done) begin
               if (r_boot_ch < BC_W'(N_CH)) begin
                  w_boot_inc   = 1'b1;
                  w_next_state = S_BOOT;
               end else begin
                  w_next_state = S_SCAN;
               end
            end
         end
         default: w_next_state = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_BOOT;
      else     r_state <= w_next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_boot_ch  <= '0;
         r_dfs_en   <= 1'b0;
         r_dfs_ch   <= '0;
         r_dfs_data <= BOOT_WORD;
         r_txn_idx  <= IDX_W'(PLL_FREQ);
         r_timer    <= '0;
         r_retry    <= '0;
         r_err      <= '0;
         r_clamp    <= '0;
         for (int c = 0; c < N_CH; c++) r_cur_idx[c] <= IDX_W'(PLL_FREQ);
      end else begin
         r_dfs_en <= w_issue | w_retry;
         // Timer holds ACK_TIMEOUT-1 on the strobe cycle so it reaches zero
         // on the last waiting cycle and the re-issue lands exactly on +ACK_TIMEOUT.
         if (w_issue) begin
            r_dfs_ch   <= w_issue_ch;
            r_dfs_data <= w_issue_word;
            r_txn_idx  <= w_issue_idx;
            r_timer    <= TMR_W'(ACK_TIMEOUT - 1);
            r_retry    <= '0;
         end else if (r_state == S_WAIT_ACK) begin
            if (w_done) begin
               r_timer <= '0;
               r_retry <= '0;
            end else if (w_retry) begin
               r_timer <= TMR_W'(ACK_TIMEOUT - 1);
               r_retry <= r_retry + 1'b1;
            end else begin
               r_timer <= r_timer - 1'b1;
            end
         end
         if (w_commit)   r_cur_idx[r_dfs_ch] <= r_txn_idx;
         if (w_err_set)  r_err <= r_err | (N_CH'(1) << r_dfs_ch);
         if (w_boot_inc) r_boot_ch <= r_boot_ch + 1'b1;
         r_clamp <= r_clamp | w_clamp_set;
      end
   end

   assign freq_pop_o = w_pop;
   assign dfs_en_o   = r_dfs_en;
   assign dfs_ch_o   = r_dfs_ch;
   assign dfs_data_o = r_dfs_data;
   assign cur_idx_o  = r_cur_idx;
   assign err_o      = r_err;
   assign clamp_o    = r_clamp;

endmodule

// File: tb/tb_multi_freq_ctrl.sv
// Scoreboard bench for multi_freq_ctrl: FIFO and DFS models, transaction-level reference.
module tb_multi_freq_ctrl;

   localparam int NC = 4;
   localparam int IW = 8;
   localparam int DW = 13;
   localparam int NF = 6;
   localparam int TO = 64;
   localparam int MR = 3;
   localparam int PLL = 1;

   typedef struct {
      int ch;
      int data;
   } cmd_t;

   int FREQ_TBL [NF] = '{480, 440, 400, 360, 320, 280};

   logic             clk = 1'b0;
   logic             rst;
   logic [NC-1:0]    enable_i;
   logic [NC*IW-1:0] freq_data_i;
   logic [NC-1:0]    freq_empty_i;
   logic [NC-1:0]    freq_pop_o;
   logic             dfs_en_o;
   logic [1:0]       dfs_ch_o;
   logic [DW-1:0]    dfs_data_o;
   logic             dfs_ack_i;
   logic [NC*IW-1:0] cur_idx_o;
   logic [NC-1:0]    err_o;
   logic [NC-1:0]    clamp_o;

   always #5 clk = ~clk;

   multi_freq_ctrl u_dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .freq_data_i  (freq_data_i),
      .freq_empty_i (freq_empty_i),
      .freq_pop_o   (freq_pop_o),
      .dfs_en_o     (dfs_en_o),
      .dfs_ch_o     (dfs_ch_o),
      .dfs_data_o   (dfs_data_o),
      .dfs_ack_i    (dfs_ack_i),
      .cur_idx_o    (cur_idx_o),
      .err_o        (err_o),
      .clamp_o      (clamp_o)
   );

   cmd_t exp_q[$];
   int   fifo [NC][$];
   int   bq   [NC][$];
   int   mcur [NC];
   bit   merr [NC];
   bit   mclamp [NC];
   int   mlast;
   int   n_vec = 0;
   int   n_fail = 0;
   int   n_en = 0;
   int   cyc = 0;
   int   en_cyc[$];
   int   ack_mode = 0;   // 0: ack after delay, 1: never ack, 2: ack on the final timeout cycle
   int   ack_fix = -1;
   int   stray_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_fifo();
      for (int c = 0; c < NC; c++) begin
         if (fifo[c].size() > 0) begin
            freq_empty_i[c]          = 1'b0;
            freq_data_i[c*IW +: IW]  = IW'(fifo[c][0]);
         end else begin
            freq_empty_i[c]          = 1'b1;
            freq_data_i[c*IW +: IW]  = '0;
         end
      end
   endtask

   // Command monitor / scoreboard
   always @(negedge clk) begin
      if (dfs_en_o === 1'b1) begin
         n_en++;
         en_cyc.push_back(cyc);
         chk("cmd_pending", longint'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            cmd_t e;
            e = exp_q.pop_front();
            chk("cmd_ch", dfs_ch_o, e.ch);
            chk("cmd_data", dfs_data_o, e.data);
         end
      end
   end

   // FIFO model: consumes the head on each pop strobe
   initial begin : fifo_drv
      logic [NC-1:0] pm;
      forever begin
         @(negedge clk);
         #4;
         pm = freq_pop_o;
         @(posedge clk);
         #1;
         for (int c = 0; c < NC; c++) begin
            if (pm[c]) begin
               chk("pop_nonempty", longint'(fifo[c].size() > 0), 1);
               if (fifo[c].size() > 0) void'(fifo[c].pop_front());
            end
         end
         drive_fifo();
      end
   end

   // DFS responder
   initial begin : ack_drv
      int d;
      int sd;
      sd = 0;
      dfs_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         if (stray_cnt != sd) begin
            sd = stray_cnt;
            dfs_ack_i = 1'b1;
            @(negedge clk);
            dfs_ack_i = 1'b0;
         end else if (dfs_en_o === 1'b1 && !rst) begin
            if (ack_mode == 0) begin
               d = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 4));
               repeat (d) @(negedge clk);
               dfs_ack_i = 1'b1;
               @(negedge clk);
               dfs_ack_i = 1'b0;
            end else if (ack_mode == 2) begin
               repeat (TO*(MR+1) - 1) @(negedge clk);
               dfs_ack_i = 1'b1;
               @(negedge clk);
               dfs_ack_i = 1'b0;
            end
         end
      end
   end

   task automatic reset_model();
      for (int c = 0; c < NC; c++) begin
         mcur[c]   = PLL;
         merr[c]   = 1'b0;
         mclamp[c] = 1'b0;
      end
      mlast = NC - 1;
   endtask

   task automatic push_cmd(input int ch, input int idx);
      cmd_t e;
      e.ch   = ch;
      e.data = FREQ_TBL[idx] & 32'h1FFF;
      exp_q.push_back(e);
   endtask

   task automatic push_boot_exp();
      for (int c = 0; c < NC; c++) if (enable_i[c]) push_cmd(c, PLL);
   endtask

   // Transaction-level reference: serve enabled non-empty queues round-robin.
   task automatic model_batch();
      int q [NC][$];
      int found;
      int idx;
      int npulse;
      for (int c = 0; c < NC; c++) q[c] = bq[c];
      found = 0;
      while (found >= 0) begin
         found = -1;
         for (int off = 1; off <= NC; off++) begin
            int c2;
            c2 = (mlast + off) % NC;
            if (found < 0 && enable_i[c2] && q[c2].size() > 0) found = c2;
         end
         if (found >= 0) begin
            mlast = found;
            idx = q[found].pop_front();
            if (idx >= NF) begin
               idx = NF - 1;
               mclamp[found] = 1'b1;
            end
            if (idx != mcur[found]) begin
               npulse = (ack_mode == 0) ? 1 : MR + 1;
               for (int p = 0; p < npulse; p++) push_cmd(found, idx);
               if (ack_mode == 1) merr[found] = 1'b1;
               else               mcur[found] = idx;
            end
         end
      end
   endtask

   task automatic check_state(input string tag);
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("%s_cur_idx%0d", tag, c), cur_idx_o[c*IW +: IW], mcur[c]);
         chk($sformatf("%s_err%0d", tag, c), err_o[c], merr[c]);
         chk($sformatf("%s_clamp%0d", tag, c), clamp_o[c], mclamp[c]);
      end
   endtask

   task automatic wait_idle(input int settle);
      int  cnt;
      bit  busy;
      cnt = 0;
      busy = 1'b1;
      while (busy && cnt < 3000) begin
         busy = (exp_q.size() != 0);
         for (int c = 0; c < NC; c++) if (enable_i[c] && fifo[c].size() > 0) busy = 1'b1;
         if (busy) begin
            @(negedge clk);
            cnt++;
         end
      end
      chk("idle_reached", longint'(cnt < 3000), 1);
      repeat (settle) @(negedge clk);
   endtask

   task automatic load_batch();
      model_batch();
      for (int c = 0; c < NC; c++) begin
         foreach (bq[c][i]) fifo[c].push_back(bq[c][i]);
         bq[c].delete();
      end
      drive_fifo();
   endtask

   task automatic run_batch(input string tag, input int settle);
      @(negedge clk);
      load_batch();
      wait_idle(settle);
      for (int c = 0; c < NC; c++) if (!enable_i[c]) fifo[c].delete();
      drive_fifo();
      check_state(tag);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_en"},   dfs_en_o, 0);
      chk({tag, "_ch"},   dfs_ch_o, 0);
      chk({tag, "_data"}, dfs_data_o, FREQ_TBL[PLL]);
      chk({tag, "_pop"},  freq_pop_o, 0);
      check_state(tag);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
      $fatal(1);
   end

   initial begin : stim
      int n0;
      int cnt;
      int nidx;
      rst          = 1'b1;
      enable_i     = '1;
      freq_data_i  = '0;
      freq_empty_i = '1;
      reset_model();
      repeat (3) @(negedge clk);
      reset_checks("rst0");

      // Boot: all channels receive the boot frequency
      push_boot_exp();
      rst = 1'b0;
      wait_idle(10);
      check_state("boot");

      // Make ch0 the last grant
      bq[0].push_back(2);
      run_batch("ch0_first", 10);

      // ch1 and ch3 pending together: ch1 then ch3
      bq[1].push_back(4);
      bq[3].push_back(4);
      run_batch("rr_order", 10);

      // Duplicate request is popped but not issued
      n0 = n_en;
      bq[2].push_back(1);
      run_batch("dup", 10);
      chk("dup_no_cmd", n_en - n0, 0);
      chk("dup_popped", fifo[2].size(), 0);

      // Out-of-range index is clamped
      bq[0].push_back(9);
      run_batch("clamp", 10);

      // Enable dropped while the command is outstanding
      ack_fix = 6;
      @(negedge clk);
      bq[2].push_back(3);
      load_batch();
      n0 = n_en;
      cnt = 0;
      while (n_en == n0 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      chk("en_drop_cmd_seen", longint'(cnt < 50), 1);
      enable_i[2] = 1'b0;
      wait_idle(12);
      enable_i = '1;
      check_state("en_drop");
      ack_fix = -1;

      // No ack at all: re-issues at +64/+128/+192, then error
      ack_mode = 1;
      en_cyc.delete();
      bq[1].push_back(0);
      run_batch("timeout", 70);
      chk("timeout_pulses", en_cyc.size(), MR + 1);
      for (int i = 1; i <= MR; i++)
         if (en_cyc.size() > i) chk($sformatf("timeout_gap%0d", i), en_cyc[i] - en_cyc[0], TO*i);

      // Ack coincides with the final timeout: commits, no error
      ack_mode = 2;
      en_cyc.delete();
      bq[3].push_back(2);
      run_batch("late_ack", 70);
      chk("late_ack_pulses", en_cyc.size(), MR + 1);

      // Errored channel is still served
      ack_mode = 0;
      bq[1].push_back(5);
      run_batch("err_served", 10);

      // Stray ack while idle has no effect
      stray_cnt++;
      repeat (6) @(negedge clk);
      check_state("stray_ack");

      // Randomized batches against the reference model
      for (int b = 0; b < 12; b++) begin
         @(negedge clk);
         enable_i = NC'($urandom_range(1, 15));
         for (int c = 0; c < NC; c++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) bq[c].push_back($urandom_range(0, 9));
         end
         run_batch($sformatf("rand%0d", b), 10);
      end
      @(negedge clk);
      enable_i = '1;

      // Reset while a command is outstanding: nothing commits
      ack_mode = 1;
      @(negedge clk);
      nidx = (mcur[0] + 1) % NF;
      push_cmd(0, nidx);
      fifo[0].push_back(nidx);
      drive_fifo();
      n0 = n_en;
      cnt = 0;
      while (n_en == n0 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      chk("midrst_cmd_seen", longint'(cnt < 50), 1);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("midrst_exp_drained", exp_q.size(), 0);
      exp_q.delete();
      for (int c = 0; c < NC; c++) fifo[c].delete();
      drive_fifo();
      reset_model();
      reset_checks("midrst");
      ack_mode = 0;
      push_boot_exp();
      rst = 1'b0;
      wait_idle(10);
      check_state("reboot");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
